// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared state encoding and score entry layout for the music sequencer
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_PAUSED,
        ST_DONE
    } state_t;

    // Score entry: [7:3] note code, [2:0] duration minus one, in beats
    localparam logic [4:0] END_CODE = 5'd31;
    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 3;
    localparam int DUR_MSB  = 2;
    localparam int DUR_LSB  = 0;

endpackage

// File: rtl/beat_tick.sv
// rtl/beat_tick.sv - beat divider, counts CLK_HZ/BEAT_HZ enabled cycles per tick
module beat_tick #(
    parameter int CLK_HZ  = 50000000,
    parameter int BEAT_HZ = 8
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_HZ / BEAT_HZ;
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - score player: walks an external note ROM and drives a tone generator
module music_sequencer
    import music_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int BEAT_HZ = 8,
    parameter int LOOP    = 0
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [4:0] code,
    output logic       mute,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic [3:0] dur_cnt;
    logic       tick;
    logic       beat_en;
    logic       beat_clr;
    logic [4:0] entry_note;
    logic [3:0] entry_beats;

    assign entry_note  = rom_data[NOTE_MSB:NOTE_LSB];
    assign entry_beats = {1'b0, rom_data[DUR_MSB:DUR_LSB]} + 4'd1;

    // Pause gates the divider directly so a tick landing on a pause cycle is lost
    assign beat_en  = (state == ST_PLAY) && !pause;
    assign beat_clr = stop || (state == ST_LOAD);

    beat_tick #(
        .CLK_HZ  (CLK_HZ),
        .BEAT_HZ (BEAT_HZ)
    ) u_beat_tick (
        .iclk   (iclk),
        .irst_n (irst_n),
        .en     (beat_en),
        .clr    (beat_clr),
        .tick   (tick)
    );

    assign busy = (state == ST_FETCH) || (state == ST_LOAD) ||
                  (state == ST_PLAY)  || (state == ST_PAUSED);
    assign done = (state == ST_DONE);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state    <= ST_IDLE;
            rom_addr <= 8'd0;
            code     <= 5'd0;
            mute     <= 1'b1;
            dur_cnt  <= 4'd0;
        end else if (stop) begin
            state    <= ST_IDLE;
            rom_addr <= 8'd0;
            code     <= 5'd0;
            mute     <= 1'b1;
            dur_cnt  <= 4'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rom_addr <= 8'd0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (entry_note == END_CODE) begin
                        if (LOOP != 0) begin
                            rom_addr <= 8'd0;
                            state    <= ST_FETCH;
                        end else begin
                            code  <= 5'd0;
                            mute  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        code    <= entry_note;
                        dur_cnt <= entry_beats;
                        mute    <= 1'b0;
                        state   <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        mute  <= 1'b1;
                        state <= ST_PAUSED;
                    end else if (tick) begin
                        dur_cnt <= dur_cnt - 4'd1;
                        // code and mute are left alone so the note boundary is glitch-free
                        if (dur_cnt == 4'd1) begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        mute  <= 1'b0;
                        state <= ST_PLAY;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - randomized and directed checks of music_sequencer against a score-level model
module tb_music_sequencer;

    localparam int CLK_HZ  = 16;
    localparam int BEAT_HZ = 2;
    localparam int BEAT    = CLK_HZ / BEAT_HZ;

    localparam int S_IDLE   = 0;
    localparam int S_FETCH  = 1;
    localparam int S_LOAD   = 2;
    localparam int S_PLAY   = 3;
    localparam int S_PAUSED = 4;
    localparam int S_DONE   = 5;

    typedef struct {
        int st;
        int addr;
        int code;
        int mute;
        int left;
        int pos;
    } model_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] rom [256];

    logic [7:0] addr0, addr1;
    logic [7:0] data0 = 8'd0;
    logic [7:0] data1 = 8'd0;
    logic [4:0] code0, code1;
    logic       mute0, mute1, busy0, busy1, done0, done1;

    int     errors   = 0;
    int     checks   = 0;
    bit     checking = 1'b0;
    model_t m0, m1;

    always #5 clk = ~clk;

    music_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .LOOP(0)) dut0 (
        .iclk(clk), .irst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .rom_addr(addr0), .rom_data(data0), .code(code0), .mute(mute0),
        .busy(busy0), .done(done0)
    );

    music_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .LOOP(1)) dut1 (
        .iclk(clk), .irst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .rom_addr(addr1), .rom_data(data1), .code(code1), .mute(mute1),
        .busy(busy1), .done(done1)
    );

    always @(posedge clk) begin
        data0 <= rom[addr0];
        data1 <= rom[addr1];
    end

    function automatic model_t reset_model();
        model_t r;
        r.st = S_IDLE; r.addr = 0; r.code = 0; r.mute = 1; r.left = 0; r.pos = 0;
        return r;
    endfunction

    function automatic model_t step(model_t s, bit loop_en, bit go, bit halt, bit hold);
        model_t     n = s;
        logic [7:0] e;
        if (halt) return reset_model();
        case (s.st)
            S_IDLE, S_DONE: if (go) begin n.addr = 0; n.st = S_FETCH; end
            S_FETCH: n.st = S_LOAD;
            S_LOAD: begin
                e = rom[s.addr];
                if (e[7:3] == 5'd31) begin
                    if (loop_en) begin n.addr = 0; n.st = S_FETCH; end
                    else begin n.st = S_DONE; n.code = 0; n.mute = 1; end
                end else begin
                    n.code = int'(e[7:3]); n.left = int'(e[2:0]) + 1;
                    n.pos = 0; n.mute = 0; n.st = S_PLAY;
                end
            end
            S_PLAY: begin
                if (hold) begin
                    n.st = S_PAUSED; n.mute = 1;
                end else if (s.pos == BEAT - 1) begin
                    n.pos = 0; n.left = s.left - 1;
                    if (n.left == 0) begin n.addr = (s.addr + 1) % 256; n.st = S_FETCH; end
                end else begin
                    n.pos = s.pos + 1;
                end
            end
            S_PAUSED: if (!hold) begin n.st = S_PLAY; n.mute = 0; end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [15:0] expect_of(model_t m);
        logic [7:0] a;
        logic [4:0] c;
        logic       mu, b, d;
        a  = m.addr[7:0];
        c  = m.code[4:0];
        mu = m.mute[0];
        b  = (m.st >= S_FETCH) && (m.st <= S_PAUSED);
        d  = (m.st == S_DONE);
        return {a, c, mu, b, d};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= reset_model();
            m1 <= reset_model();
        end else begin
            m0 <= step(m0, 1'b0, start, stop, pause);
            m1 <= step(m1, 1'b1, start, stop, pause);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("model_loop0", {addr0, code0, mute0, busy0, done0}, expect_of(m0));
            check("model_loop1", {addr1, code1, mute1, busy1, done1}, expect_of(m1));
        end
    end

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0; @(negedge clk);
    endtask

    initial begin
        int n, c1, c11, muted, play;
        for (int i = 0; i < 256; i++) rom[i] = 8'hF8;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checking = 1'b1;
        check("reset_state", {addr0, code0, mute0, busy0, done0}, {8'd0, 5'd0, 1'b1, 1'b0, 1'b0});

        // Three-entry score: 3 beats of note 1, 2 beats of note 11, end
        rom[0] = 8'h0A; rom[1] = 8'h59; rom[2] = 8'hF8;
        pulse_start();
        n = 0; c1 = 0; c11 = 0;
        while (busy0 && n < 200) begin
            if (code0 == 5'd1)  c1++;
            if (code0 == 5'd11) c11++;
            n++;
            @(negedge clk);
        end
        check("score_busy_cycles", n, 46);
        check("score_note1_cycles", c1, 26);
        check("score_note11_cycles", c11, 18);
        check("score_done_state", {done0, mute0, code0}, {1'b1, 1'b1, 5'd0});
        check("loop_restart", {done1, busy1, addr1}, {1'b0, 1'b1, 8'd0});
        n = 0;
        while (code1 != 5'd1 && n < 6) begin @(negedge clk); n++; end
        check("loop_replay_note1", {code1, mute1}, {5'd1, 1'b0});
        pulse_stop();

        // Pause 20 cycles at cycle 5 of a 1-beat note
        rom[0] = 8'h08; rom[1] = 8'h08; rom[2] = 8'hF8;
        pulse_start();
        n = 0;
        while (mute0 && n < 10) begin @(negedge clk); n++; end
        check("pause_note_started", mute0, 1'b0);
        repeat (5) @(negedge clk);
        pause = 1'b1;
        muted = 0;
        repeat (20) begin @(negedge clk); if (mute0) muted++; end
        pause = 1'b0;
        check("pause_muted_cycles", muted, 20);
        play = 0; n = 0;
        @(negedge clk);
        while (addr0 == 8'd0 && n < 20) begin
            if (!mute0) play++;
            n++;
            @(negedge clk);
        end
        check("pause_resume_cycles", play, 3);
        check("pause_next_addr", addr0, 8'd1);

        // stop and start together mid-note
        repeat (3) @(negedge clk);
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        check("stop_start_loop0", {addr0, code0, mute0, busy0}, {8'd0, 5'd0, 1'b1, 1'b0});
        check("stop_start_loop1", {addr1, code1, mute1, busy1}, {8'd0, 5'd0, 1'b1, 1'b0});
        @(negedge clk);
        check("stop_start_stays_idle", busy0, 1'b0);

        // Asynchronous reset mid-note
        pulse_start();
        n = 0;
        while (mute0 && n < 10) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("pre_reset_playing", {busy0, mute0}, {1'b1, 1'b0});
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_loop0", {addr0, code0, mute0, busy0, done0}, {8'd0, 5'd0, 1'b1, 1'b0, 1'b0});
        check("async_reset_loop1", {addr1, code1, mute1, busy1, done1}, {8'd0, 5'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        check("first_start_after_reset", busy0, 1'b1);
        pulse_stop();

        // 256 one-beat notes, no end marker: address wraps
        for (int i = 0; i < 256; i++) rom[i] = 8'((i % 31) << 3);
        pulse_start();
        n = 0;
        while (addr0 != 8'd255 && n < 3000) begin @(negedge clk); n++; end
        check("wrap_reached_255", addr0, 8'd255);
        n = 0;
        while (addr0 == 8'd255 && n < 20) begin @(negedge clk); n++; end
        check("wrap_to_zero", {addr0, busy0}, {8'd0, 1'b1});
        repeat (30) @(negedge clk);
        pulse_stop();

        // Randomized score and control traffic, checked by the model every cycle
        for (int i = 0; i < 256; i++) begin
            logic [4:0] nc;
            logic [2:0] du;
            nc = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            du = 3'($urandom_range(0, 2));
            rom[i] = {nc, du};
        end
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        @(negedge clk);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning iclk frequency in Hz.
REQ-002 SHALL have parameter BEAT_HZ, default 8, meaning beat-tick rate (one duration unit).
REQ-003 SHALL have parameter LOOP, default 0, meaning 1 = restart at address 0 on end marker.
REQ-004 SHALL have port iclk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port irst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins playback.
REQ-007 SHALL have port stop, input, 1 bit: single-cycle pulse that aborts playback.
REQ-008 SHALL have port pause, input, 1 bit: level; high holds playback.
REQ-009 SHALL have port rom_addr, output, 8 bits: score ROM address.
REQ-010 SHALL have port rom_data, input, 8 bits: score entry, valid one cycle after rom_addr; [7:3] = note code, [2:0] = duration minus 1, in beats.
REQ-011 SHALL have port code, output, 5 bits: note code to the tone-table generator.
REQ-012 SHALL have port mute, output, 1 bit: 1 = speaker gated off.
REQ-013 SHALL have port busy, output, 1 bit: high in FETCH, LOAD, PLAY and PAUSED.
REQ-014 SHALL have port done, output, 1 bit: level, high in DONE.

Function
REQ-015 States SHALL be IDLE, FETCH, LOAD, PLAY, PAUSED and DONE.
REQ-016 IDLE or DONE, on start: rom_addr <= 0, next state FETCH.
REQ-017 FETCH SHALL last exactly 1 cycle and then go to LOAD, covering ROM latency.
REQ-018 LOAD with rom_data[7:3] == 5'd31 (end marker) SHALL go to FETCH with rom_addr <= 0 if LOOP = 1, else to DONE.
REQ-019 LOAD with any other code: code <= rom_data[7:3], dur_cnt <= rom_data[2:0] + 1 (range 1..8), beat counter cleared, mute <= 0, next state PLAY.
REQ-020 Beat counter SHALL count 0 .. CLK_HZ/BEAT_HZ-1 in PLAY only; the terminal count is the beat tick.
REQ-021 In PLAY, each beat tick SHALL decrement dur_cnt.
REQ-022 A beat tick with dur_cnt == 1 SHALL set rom_addr <= rom_addr + 1 (modulo 256, 255 wraps to 0) and go to FETCH.
REQ-023 code SHALL hold the previous note through FETCH/LOAD, giving a 2-cycle boundary with no mute glitch.
REQ-024 PLAY with pause high SHALL go to PAUSED, freezing the beat counter and dur_cnt, with mute = 1.
REQ-025 PAUSED with pause low SHALL return to PLAY, resuming the counts unchanged.
REQ-026 pause in FETCH/LOAD SHALL take effect on the first PLAY cycle.
REQ-027 stop in any state SHALL go to IDLE next cycle: mute = 1, code = 0, rom_addr = 0.
REQ-028 stop SHALL override a simultaneous start.
REQ-029 A beat tick coinciding with pause SHALL be discarded; the beat counter holds.
REQ-030 start outside IDLE/DONE SHALL be ignored.
REQ-031 In IDLE and DONE, mute SHALL be 1 and code SHALL be 0.

Reset
REQ-032 irst_n low SHALL asynchronously force state IDLE, code 0, mute 1, rom_addr 0, busy 0, done 0, dur_cnt 0 and beat counter 0, including mid-note.
REQ-033 The first start after irst_n deasserts SHALL be honoured.

Structure
REQ-034 State encoding, END_CODE = 5'd31 and score field positions SHALL live in shared package music_pkg.
REQ-035 The beat counter SHALL be sub-module beat_tick (ports: iclk, irst_n, en, clr, tick), parameterised by CLK_HZ and BEAT_HZ.
REQ-036 The score ROM SHALL be external to this block.

Verification (CLK_HZ=16, BEAT_HZ=2, i.e. 8 cycles per beat)
REQ-037 Score {0x0A, 0x59, 0xF8}, start: code = 1 for 24 cycles, then 2 cycles boundary, then code = 11 for 16 cycles; DONE with done = 1 and mute = 1.
REQ-038 Same score, LOOP = 1: after the end marker, rom_addr returns to 0 and code = 1 replays; done stays 0.
REQ-039 pause high for 20 cycles at cycle 5 of a 1-beat note: mute = 1 during the pause, and the note completes 3 cycles after pause falls.
REQ-040 stop and start in the same cycle mid-note: next cycle IDLE, code = 0, mute = 1, busy = 0.
REQ-041 irst_n low mid-PLAY: all outputs at reset values immediately, without waiting for a clock edge.
REQ-042 256 entries of 1-beat notes with no end marker: rom_addr wraps 255 -> 0 and playback continues.
